i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Turns a single register read/write request into the sequence of byte-level
//   commands an I2C byte controller needs: start + device address, register
//   pointer, then either the write data + stop, or a repeated start, one
//   received byte and a master NACK.  Each controller command is a one-cycle
//   pulse, followed by a wait for the controller to go busy and come back idle.
//   A per-state cycle counter aborts any state that hangs.
//
// Ports
//   clk, reset                     system clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only when idle)
//   req_rd, req_dev, req_reg,      request fields, latched on acceptance
//   req_wdata
//   resp_valid, resp_rdata,        one-cycle response with read data / error
//   resp_err
//   c_addr, c_r_wbar, c_data       command operands to the byte controller
//   c_send_start, c_write_enable,  one-cycle command pulses
//   c_send_nack, c_send_stop
//   c_idle, c_ack, c_nack,         controller status
//   c_ongoing, c_rx_data
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic [6:0] c_addr,
  output logic       c_r_wbar,
  output logic       c_send_start,
  output logic [7:0] c_data,
  output logic       c_write_enable,
  output logic       c_send_nack,
  output logic       c_send_stop,
  input  logic       c_idle,
  input  logic       c_ack,
  input  logic       c_nack,
  input  logic       c_ongoing,
  input  logic [7:0] c_rx_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_START_W, S_REG, S_DATA, S_START_R,
    S_RDWAIT, S_NACK, S_STOP, S_END, S_RESP
  } state_t;

  // Sub-phase of one controller operation: issue the pulse, wait for the
  // controller to drop c_idle, then wait for it to come back.
  typedef enum logic [1:0] {P_ISSUE, P_WAIT_LOW, P_WAIT_HIGH} phase_t;

  state_t      state, state_next;
  phase_t      phase, phase_next;
  logic        lat_rd;
  logic [6:0]  lat_dev;
  logic [7:0]  lat_reg, lat_wdata, rx_byte;
  logic        err_flag, saw_ack, saw_nack;
  logic [1:0]  low_cnt;
  logic [31:0] tmo_cnt;
  logic        can_issue, op_done, op_fail, timeout, accept;
  logic        issue_start, issue_write, issue_nack, issue_stop;
  logic        set_err, cap_rx;

  assign accept    = req_valid && (state == S_IDLE);
  assign timeout   = (tmo_cnt == TIMEOUT_CYCLES);
  assign can_issue = (phase == P_ISSUE) && c_idle;
  // An operation also counts as complete when c_idle never dropped within
  // four cycles of the pulse (the controller treated it as a no-op).
  assign op_done   = ((phase == P_WAIT_HIGH) && c_idle) ||
                     ((phase == P_WAIT_LOW) && c_idle && (low_cnt == 2'd3));
  // ACK/NACK may be a short pulse, so the sticky copies are consulted too.
  // No acknowledgement at all is treated like a NACK.
  assign op_fail   = saw_nack || c_nack || !(saw_ack || c_ack);

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && err_flag;
  assign resp_rdata = (resp_valid && lat_rd && !err_flag) ? rx_byte : 8'h00;

  // Next-state and command decode; timeout overrides all normal progress.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    issue_start = 1'b0;
    issue_write = 1'b0;
    issue_nack  = 1'b0;
    issue_stop  = 1'b0;
    set_err     = 1'b0;
    cap_rx      = 1'b0;
    if ((phase == P_WAIT_LOW) && !c_idle) phase_next = P_WAIT_HIGH;
    if (timeout && (state != S_IDLE) && (state != S_RESP)) begin
      set_err = 1'b1;
      case (state)
        S_START_W, S_REG, S_DATA, S_START_R, S_RDWAIT:
          state_next = c_ongoing ? S_STOP : S_RESP;
        default: state_next = S_RESP;
      endcase
    end else begin
      case (state)
        S_IDLE: if (req_valid) state_next = S_START_W;
        S_START_W: begin
          issue_start = can_issue;
          if (op_done) begin
            set_err    = op_fail;
            state_next = op_fail ? S_STOP : S_REG;
          end
        end
        S_REG: begin
          issue_write = can_issue;
          if (op_done) begin
            set_err = op_fail;
            if (op_fail)     state_next = S_STOP;
            else if (lat_rd) state_next = S_START_R;
            else             state_next = S_DATA;
          end
        end
        S_DATA: begin
          issue_write = can_issue;
          if (op_done) begin
            set_err    = op_fail;
            state_next = S_STOP;
          end
        end
        S_START_R: begin
          issue_start = can_issue;
          if (op_done) begin
            set_err    = op_fail;
            state_next = op_fail ? S_STOP : S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (op_done) begin
            cap_rx     = 1'b1;
            state_next = S_NACK;
          end
        end
        S_NACK: begin
          issue_nack = can_issue;
          if (op_done) state_next = S_END;
        end
        S_STOP: begin
          issue_stop = can_issue;
          if (op_done) state_next = S_END;
        end
        S_END:   if (c_idle && !c_ongoing) state_next = S_RESP;
        S_RESP:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
    if (issue_start || issue_write || issue_nack || issue_stop) phase_next = P_WAIT_LOW;
    // The read byte arrives without a pulse, so S_RDWAIT starts already waiting.
    if (state_next != state) phase_next = (state_next == S_RDWAIT) ? P_WAIT_LOW : P_ISSUE;
  end

  // State register, command outputs, request latches and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= P_ISSUE;
      c_send_start   <= 1'b0;
      c_write_enable <= 1'b0;
      c_send_nack    <= 1'b0;
      c_send_stop    <= 1'b0;
      c_addr         <= 7'h00;
      c_r_wbar       <= 1'b0;
      c_data         <= 8'h00;
      lat_rd         <= 1'b0;
      lat_dev        <= 7'h00;
      lat_reg        <= 8'h00;
      lat_wdata      <= 8'h00;
      rx_byte        <= 8'h00;
      err_flag       <= 1'b0;
      saw_ack        <= 1'b0;
      saw_nack       <= 1'b0;
      low_cnt        <= 2'd0;
      tmo_cnt        <= 32'd0;
    end else begin
      state          <= state_next;
      phase          <= phase_next;
      c_send_start   <= issue_start;
      c_write_enable <= issue_write;
      c_send_nack    <= issue_nack;
      c_send_stop    <= issue_stop;
      if (issue_start) begin
        c_addr   <= lat_dev;
        c_r_wbar <= (state == S_START_R);
      end
      if (issue_write) c_data <= (state == S_REG) ? lat_reg : lat_wdata;
      if (accept) begin
        lat_rd    <= req_rd;
        lat_dev   <= req_dev;
        lat_reg   <= req_reg;
        lat_wdata <= req_wdata;
        rx_byte   <= 8'h00;
        err_flag  <= 1'b0;
      end
      if (set_err) err_flag <= 1'b1;
      if (cap_rx)  rx_byte  <= c_rx_data;
      if (issue_start || issue_write || issue_nack || issue_stop || (state_next != state)) begin
        saw_ack  <= 1'b0;
        saw_nack <= 1'b0;
      end else begin
        if (c_ack)  saw_ack  <= 1'b1;
        if (c_nack) saw_nack <= 1'b1;
      end
      if ((state_next != state) || (phase_next != phase)) low_cnt <= 2'd0;
      else if (phase == P_WAIT_LOW)                       low_cnt <= low_cnt + 2'd1;
      if ((state_next != state) || (state == S_IDLE)) tmo_cnt <= 32'd0;
      else                                            tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer
//   Drives i2c_reg_sequencer against a behavioural byte controller with one
//   slave at address 0x50 (a 256-byte register file; data writes to registers
//   0xF0 and above are NACKed).  Expected bus events and responses come from a
//   transaction-level model of the slave.
module tb_i2c_reg_sequencer;

  localparam logic [6:0] SLAVE_DEV = 7'h50;
  localparam logic [7:0] EV_START = 8'd1, EV_WR = 8'd2, EV_RD = 8'd3, EV_NACK = 8'd4, EV_STOP = 8'd5;
  localparam int OP_NONE = 0, OP_ADDR = 1, OP_BYTE = 2, OP_RECV = 3, OP_END = 4;

  logic       clk, reset;
  logic       req_valid, req_ready, req_rd;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       resp_valid, resp_err;
  logic [7:0] resp_rdata;
  logic [6:0] c_addr;
  logic       c_r_wbar, c_send_start, c_write_enable, c_send_nack, c_send_stop;
  logic [7:0] c_data;
  logic       c_idle, c_ack, c_nack, c_ongoing;
  logic [7:0] c_rx_data;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .c_addr(c_addr), .c_r_wbar(c_r_wbar), .c_send_start(c_send_start),
    .c_data(c_data), .c_write_enable(c_write_enable), .c_send_nack(c_send_nack),
    .c_send_stop(c_send_stop), .c_idle(c_idle), .c_ack(c_ack), .c_nack(c_nack),
    .c_ongoing(c_ongoing), .c_rx_data(c_rx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total, passed;
  int cyc, accept_cnt, resp_cnt, accept_cyc, resp_cyc, proto_viol;
  logic       last_err;
  logic [7:0] last_rdata;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] slave_mem [256];
  bit   mem_ready;
  bit   stall;
  int   busy, recv_delay, op, byte_idx;
  bit   op_ok, op_rd;
  logic [7:0] ptr;

  function automatic logic [7:0] memInit(input logic [7:0] a);
    return (a == 8'h22) ? 8'h3C : (a * 8'd37 + 8'd11);
  endfunction

  // Bus monitor plus behavioural byte controller / slave, all on the falling
  // edge so that DUT registers are stable when observed.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (!mem_ready) begin
        for (int i = 0; i < 256; i++) slave_mem[i] <= memInit(8'(i));
        mem_ready <= 1'b1;
      end
      c_idle <= 1'b1; c_ongoing <= 1'b0; c_ack <= 1'b0; c_nack <= 1'b0;
      c_rx_data <= 8'h00; busy <= 0; recv_delay <= 0; op <= OP_NONE;
      op_ok <= 1'b0; op_rd <= 1'b0; byte_idx <= 0; ptr <= 8'h00;
    end else begin
      if (req_valid && req_ready) begin accept_cnt++; accept_cyc = cyc; end
      if (resp_valid) begin
        resp_cnt++; resp_cyc = cyc; last_err = resp_err; last_rdata = resp_rdata;
      end
      if ((int'(c_send_start) + int'(c_write_enable) + int'(c_send_nack) + int'(c_send_stop)) > 1) proto_viol++;
      if ((c_send_start || c_write_enable || c_send_nack || c_send_stop) && !c_idle) proto_viol++;
      c_ack <= 1'b0; c_nack <= 1'b0;
      if (c_send_start) begin
        obs_q.push_back({EV_START, c_addr, c_r_wbar});
        c_idle <= 1'b0; c_ongoing <= 1'b1; op <= OP_ADDR;
        busy <= stall ? 0 : int'($urandom_range(2, 6));
        op_ok <= (c_addr == SLAVE_DEV); op_rd <= c_r_wbar; byte_idx <= 0;
      end else if (c_write_enable) begin
        obs_q.push_back({EV_WR, c_data});
        c_idle <= 1'b0; op <= OP_BYTE; busy <= int'($urandom_range(2, 6));
        op_ok <= !(byte_idx == 1 && ptr >= 8'hF0);
        if (byte_idx == 0) ptr <= c_data;
        else if (ptr < 8'hF0) slave_mem[ptr] <= c_data;
        byte_idx <= byte_idx + 1;
      end else if (c_send_nack || c_send_stop) begin
        obs_q.push_back({c_send_nack ? EV_NACK : EV_STOP, 8'h00});
        c_idle <= 1'b0; op <= OP_END; busy <= int'($urandom_range(2, 6));
      end else if (busy == 1) begin
        busy <= 0; c_idle <= 1'b1;
        case (op)
          OP_ADDR: begin
            c_ack <= op_ok; c_nack <= !op_ok;
            if (op_ok && op_rd) recv_delay <= 2;
          end
          OP_BYTE: begin c_ack <= op_ok; c_nack <= !op_ok; end
          OP_RECV: begin
            c_rx_data <= slave_mem[ptr];
            obs_q.push_back({EV_RD, slave_mem[ptr]});
          end
          OP_END:  c_ongoing <= 1'b0;
          default: ;
        endcase
      end else if (busy > 1) begin
        busy <= busy - 1;
      end else if (recv_delay == 1) begin
        recv_delay <= 0; c_idle <= 1'b0; op <= OP_RECV; busy <= int'($urandom_range(2, 6));
      end else if (recv_delay > 1) begin
        recv_delay <= recv_delay - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Transaction-level reference: what the bus must carry and what the
  // response must say, from the slave's register file and address.
  task automatic predictTxn(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, output bit err, output logic [7:0] rdata);
    exp_q.push_back({EV_START, dev, 1'b0});
    rdata = 8'h00;
    if (dev != SLAVE_DEV) begin
      exp_q.push_back({EV_STOP, 8'h00});
      err = 1'b1;
    end else if (!rd) begin
      exp_q.push_back({EV_WR, rg});
      exp_q.push_back({EV_WR, wd});
      exp_q.push_back({EV_STOP, 8'h00});
      err = (rg >= 8'hF0);
      if (!err) ref_mem[rg] = wd;
    end else begin
      exp_q.push_back({EV_WR, rg});
      exp_q.push_back({EV_START, dev, 1'b1});
      exp_q.push_back({EV_RD, ref_mem[rg]});
      exp_q.push_back({EV_NACK, 8'h00});
      err = 1'b0;
      rdata = ref_mem[rg];
    end
  endtask

  task automatic compareEvents(input int base, input string tag);
    logic [15:0] o;
    checkOutput({tag, ".nevents"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hFFFF;
      checkOutput($sformatf("%s.ev%0d", tag, i), o, exp_q[i]);
    end
  endtask

  task automatic waitCycles(input int limit, input bit for_resp, input int target);
    int n = 0;
    while (((for_resp ? resp_cnt : accept_cnt) < target) && n < limit) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic applyStimulus(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd, input string tag);
    bit e; logic [7:0] d; int base, a0, r0;
    exp_q.delete();
    predictTxn(rd, dev, rg, wd, e, d);
    base = obs_q.size(); a0 = accept_cnt; r0 = resp_cnt;
    req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    waitCycles(50, 1'b0, a0 + 1);
    req_valid = 1'b0;
    waitCycles(400, 1'b1, r0 + 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, ".accepts"}, accept_cnt - a0, 1);
    checkOutput({tag, ".resps"}, resp_cnt - r0, 1);
    checkOutput({tag, ".err"}, last_err, e);
    checkOutput({tag, ".rdata"}, last_rdata, d);
    compareEvents(base, tag);
  endtask

  initial begin
    bit eA, eB; logic [7:0] dA, dB, firstRdata; logic firstErr;
    int base, a0, r0;
    for (int i = 0; i < 256; i++) ref_mem[i] = memInit(8'(i));
    req_valid = 1'b0; req_rd = 1'b0; req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;
    stall = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst.ready", req_ready, 1);
    checkOutput("rst.resp_valid", resp_valid, 0);
    checkOutput("rst.resp_err", resp_err, 0);
    checkOutput("rst.resp_rdata", resp_rdata, 0);
    checkOutput("rst.pulses", {c_send_start, c_write_enable, c_send_nack, c_send_stop}, 0);
    checkOutput("rst.c_addr", c_addr, 0);
    checkOutput("rst.c_data", c_data, 0);
    checkOutput("rst.c_r_wbar", c_r_wbar, 0);

    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, "write");
    applyStimulus(1'b1, 7'h50, 8'h22, 8'h00, "read");
    applyStimulus(1'b0, 7'h51, 8'h10, 8'h77, "addrnack");
    applyStimulus(1'b0, 7'h50, 8'hF3, 8'h12, "datanack");

    // Request held valid through two back-to-back transactions.
    exp_q.delete();
    predictTxn(1'b0, 7'h50, 8'h33, 8'h5A, eA, dA);
    predictTxn(1'b1, 7'h50, 8'h33, 8'h00, eB, dB);
    base = obs_q.size(); a0 = accept_cnt; r0 = resp_cnt;
    req_rd = 1'b0; req_dev = 7'h50; req_reg = 8'h33; req_wdata = 8'h5A; req_valid = 1'b1;
    waitCycles(400, 1'b1, r0 + 1);
    checkOutput("held.accepts_first", accept_cnt - a0, 1);
    firstErr = last_err; firstRdata = last_rdata;
    req_rd = 1'b1; req_wdata = 8'h00;
    waitCycles(50, 1'b0, a0 + 2);
    req_valid = 1'b0;
    checkOutput("held.next_accept_gap", accept_cyc - resp_cyc, 1);
    waitCycles(400, 1'b1, r0 + 2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held.accepts", accept_cnt - a0, 2);
    checkOutput("held.resps", resp_cnt - r0, 2);
    checkOutput("held.errA", firstErr, eA);
    checkOutput("held.rdataA", firstRdata, dA);
    checkOutput("held.errB", last_err, eB);
    checkOutput("held.rdataB", last_rdata, dB);
    compareEvents(base, "held");

    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 7'h51 : 7'h50,
                    ($urandom_range(0, 4) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, 7)),
                    8'($urandom), $sformatf("rnd%0d", k));
    end

    // Reset while the register-pointer byte is in flight.
    base = obs_q.size(); a0 = accept_cnt; r0 = resp_cnt;
    req_rd = 1'b1; req_dev = 7'h50; req_reg = 8'h44; req_valid = 1'b1;
    waitCycles(50, 1'b0, a0 + 1);
    req_valid = 1'b0;
    for (int n = 0; n < 100 && obs_q.size() < base + 2; n++) begin @(posedge clk); #1; end
    checkOutput("midrst.reg_byte", (obs_q.size() >= base + 2) ? obs_q[base + 1] : 16'hFFFF, {EV_WR, 8'h44});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("midrst.ready", req_ready, 1);
    checkOutput("midrst.pulses", {c_send_start, c_write_enable, c_send_nack, c_send_stop}, 0);
    base = obs_q.size();
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midrst.no_resp", resp_cnt - r0, 0);
    checkOutput("midrst.no_pulses", obs_q.size() - base, 0);

    // Controller never returns to idle after the start pulse.
    stall = 1'b1;
    base = obs_q.size(); a0 = accept_cnt; r0 = resp_cnt;
    req_rd = 1'b0; req_dev = 7'h50; req_reg = 8'h01; req_wdata = 8'h02; req_valid = 1'b1;
    waitCycles(50, 1'b0, a0 + 1);
    req_valid = 1'b0;
    waitCycles(400, 1'b1, r0 + 1);
    checkOutput("tmo.resps", resp_cnt - r0, 1);
    checkOutput("tmo.err", last_err, 1);
    checkOutput("tmo.rdata", last_rdata, 0);
    checkOutput("tmo.window", (resp_cnt > r0) && (resp_cyc - accept_cyc >= 100) && (resp_cyc - accept_cyc <= 300), 1);
    checkOutput("tmo.nevents", obs_q.size() - base, 1);
    checkOutput("tmo.start", (obs_q.size() > base) ? obs_q[base] : 16'hFFFF, {EV_START, 7'h50, 1'b0});
    stall = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("tmo.ready_after_reset", req_ready, 1);

    checkOutput("protocol", proto_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
